// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e : IDLE / RUN / HALT control states
//   - redir_kind_e  : encodings of the redir_kind input
//   - FIFO sizing   : depth, count width, payload width {instr, pc4}
//   - redirect_target() : computes the redirect address for each kind
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    RK_BRANCH = 2'd0,
    RK_JUMP   = 2'd1,
    RK_JR     = 2'd2,
    RK_RSVD   = 2'd3
  } redir_kind_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;
  localparam int FIFO_W     = 64;
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

  // Branch (and the reserved kind) is PC-relative with a word-scaled,
  // sign-extended immediate; jump keeps the top nibble of pc4; jump-register
  // takes the register value as-is. Additions wrap modulo 2^32.
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  kind,
    input logic [31:0] pc4,
    input logic [15:0] imm,
    input logic [25:0] target,
    input logic [31:0] jr
  );
    logic [31:0] t;
    case (kind)
      RK_JUMP: t = {pc4[31:28], target, 2'b00};
      RK_JR:   t = jr;
      default: t = pc4 + {{14{imm[15]}}, imm, 2'b00};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry FIFO holding fetched {instruction, pc4} pairs for decode.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data at the tail (ignored when full without pop)
//   pop         : drop the head (ignored when empty)
//   flush       : empty the FIFO; dominates push and pop
//   push_data   : 64-bit payload {instr, pc4}
//   head_data   : current head entry (meaningful only when count != 0)
//   count       : number of valid entries, 0..2
// Push and pop in the same cycle are legal at any count, including full.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [FIFO_W-1:0]     push_data,
  output logic [FIFO_W-1:0]     head_data,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [FIFO_W-1:0] mem [FIFO_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && ((count != FIFO_FULL) || do_pop) && !flush && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity comes only
  // from count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: PC register, fetch control FSM, and a 2-entry
// instruction FIFO toward decode. Memory has a fixed one-cycle read latency.
// Parameters:
//   RESET_PC      : fetch address loaded on reset
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   im_addr       : instruction memory address (the PC register)
//   fetch_req     : read im_addr this cycle
//   im_data       : read data, valid the cycle after fetch_req
//   instr_out     : FIFO head instruction (0 when invalid)
//   instr_pc4     : PC+4 of instr_out (0 when invalid)
//   instr_valid   : FIFO head valid
//   instr_ready   : decode accepts the head this cycle
//   redirect      : one-cycle flow change request
//   redir_kind    : 0 branch, 1 jump, 2 jump-register, 3 treated as branch
//   redir_pc4     : PC+4 of the redirecting instruction
//   redir_imm     : branch immediate
//   redir_target  : jump target field
//   redir_jr      : jump-register address
//   misalign_err  : sticky misaligned-redirect flag
// Configuration macro FETCH_ALIGN_CHECK_EN:
//   defined   -> misaligned redirect target sets misalign_err, flushes and
//                halts with the PC unchanged
//   undefined -> target[1:0] is forced to 0 and misalign_err is tied low
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  output logic        fetch_req,
  input  logic [31:0] im_data,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_target,
  input  logic [31:0] redir_jr,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;

  logic [31:0]           pc_q;
  logic                  inflight_q;
  logic [31:0]           target_raw;
  logic [31:0]           target;
  logic                  target_bad;
  logic                  issue;
  logic                  flush;
  logic                  pc_load;
  logic                  pop;
  logic                  push;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_W-1:0]     head;
  logic [FIFO_CNT_W-1:0] credits_used;

  assign target_raw = redirect_target(redir_kind, redir_pc4, redir_imm,
                                      redir_target, redir_jr);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target     = target_raw;
  assign target_bad = (target_raw[1:0] != 2'b00);

  // Set on the transition into HALT, which only a misaligned redirect causes.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (state_d == ST_HALT && state_q != ST_HALT) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign target       = target_raw & 32'hFFFF_FFFC;
  assign target_bad   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;

  // Credits: entries left after this cycle's pop plus the response still on
  // its way. Keeping this below the depth means a response always has a slot.
  assign credits_used = fifo_count - FIFO_CNT_W'(pop) + FIFO_CNT_W'(inflight_q);

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    flush   = 1'b0;
    pc_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        if (redirect) begin
          if (target_bad) state_d = ST_HALT;
          else            pc_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          flush = 1'b1;
          if (target_bad) state_d = ST_HALT;
          else            pc_load = 1'b1;
        end else if (credits_used < FIFO_FULL) begin
          issue = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (pc_load)    pc_q <= target;
      else if (issue) pc_q <= pc_q + 32'd4;
    end
  end

  // The PC already advanced at the issuing edge, so during the response
  // cycle pc_q holds the issuing PC+4.
  assign push = inflight_q && !redirect;

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({im_data, pc_q}),
    .head_data (head),
    .count     (fifo_count)
  );

  assign im_addr   = pc_q;
  assign fetch_req = issue && !reset;
  assign instr_out = instr_valid ? head[63:32] : 32'h0;
  assign instr_pc4 = instr_valid ? head[31:0]  : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The memory model returns the fetched
// address as the instruction. A scoreboard queue receives {addr, addr+4} for
// each fetch and is compared in order against instructions accepted by decode;
// redirect and reset empty it. Redirect targets come from a constant table.
// A second instance with RESET_PC = 0xFFFF_FFFC checks PC wrap after reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] im_addr;
  logic        fetch_req;
  logic [31:0] im_data = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc4;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [1:0]  redir_kind = 2'd0;
  logic [31:0] redir_pc4 = 32'h0;
  logic [15:0] redir_imm = 16'h0;
  logic [25:0] redir_target = 26'h0;
  logic [31:0] redir_jr = 32'h0;
  logic        misalign_err;

  logic [31:0] w_im_addr;
  logic        w_fetch_req;
  logic [31:0] w_instr_out;
  logic [31:0] w_instr_pc4;
  logic        w_instr_valid;
  logic        w_misalign_err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] model_pc  = 32'h0;
  logic [31:0] redir_exp = 32'h0;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] jr;
    logic [31:0] exp;
  } redir_vec_t;

  redir_vec_t vecs[8];

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .im_addr      (im_addr),
    .fetch_req    (fetch_req),
    .im_data      (im_data),
    .instr_out    (instr_out),
    .instr_pc4    (instr_pc4),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redir_kind   (redir_kind),
    .redir_pc4    (redir_pc4),
    .redir_imm    (redir_imm),
    .redir_target (redir_target),
    .redir_jr     (redir_jr),
    .misalign_err (misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .im_addr      (w_im_addr),
    .fetch_req    (w_fetch_req),
    .im_data      (32'h0),
    .instr_out    (w_instr_out),
    .instr_pc4    (w_instr_pc4),
    .instr_valid  (w_instr_valid),
    .instr_ready  (1'b1),
    .redirect     (1'b0),
    .redir_kind   (2'd0),
    .redir_pc4    (32'h0),
    .redir_imm    (16'h0),
    .redir_target (26'h0),
    .redir_jr     (32'h0),
    .misalign_err (w_misalign_err)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory returning the address; junk when not reading.
  always @(posedge clk) begin
    im_data <= fetch_req ? im_addr : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      model_pc = 32'h0;
    end else if (redirect) begin
      sb_q.delete();
      model_pc = redir_exp;
    end else begin
      if (instr_valid && instr_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_extra: got instr %h expected none", instr_out);
        end else begin
          sb_entry_t e;
          e = sb_q.pop_front();
          check("sb_instr", instr_out, e.instr);
          check("sb_pc4", instr_pc4, e.pc4);
        end
      end
      if (fetch_req) begin
        check("sb_fetch_addr", im_addr, model_pc);
        sb_q.push_back({model_pc, model_pc + 32'd4});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input bit rand_ready);
    for (int k = 0; k < n; k++) begin
      cyc();
      instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic drive_redir(input logic [1:0] kind, input logic [31:0] pc4,
                             input logic [15:0] imm, input logic [25:0] tgt,
                             input logic [31:0] jr);
    redirect     = 1'b1;
    redir_kind   = kind;
    redir_pc4    = pc4;
    redir_imm    = imm;
    redir_target = tgt;
    redir_jr     = jr;
  endtask

  task automatic do_reset();
    cyc();
    reset       = 1'b1;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    check("rst_im_addr", im_addr, 32'h0);
    check("rst_fetch_req", fetch_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_instr_pc4", instr_pc4, 32'h0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_wrap_addr", w_im_addr, 32'hFFFF_FFFC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;

    vecs[0] = '{2'd0, 32'h0000_0100, 16'hFFFF, 26'h0,       32'h0,         32'h0000_00FC};
    vecs[1] = '{2'd0, 32'h0000_0200, 16'h0010, 26'h0,       32'h0,         32'h0000_0240};
    vecs[2] = '{2'd1, 32'h9000_0000, 16'h0,    26'h0000010, 32'h0,         32'h9000_0040};
    vecs[3] = '{2'd2, 32'h0,         16'h0,    26'h0,       32'h0000_1234, 32'h0000_1234};
    vecs[4] = '{2'd3, 32'h0000_1000, 16'h0004, 26'h0,       32'h0,         32'h0000_1010};
    vecs[5] = '{2'd0, 32'hFFFF_FFF0, 16'h0008, 26'h0,       32'h0,         32'h0000_0010};
    vecs[6] = '{2'd1, 32'h3FFF_FFFC, 16'h0,    26'h3FFFFFF, 32'h0,         32'h3FFF_FFFC};
    vecs[7] = '{2'd2, 32'h0,         16'h0,    26'h0,       32'hFFFF_FFF8, 32'hFFFF_FFF8};

    // Reset release and first-instruction latency, plus wrap instance.
    do_reset();
    cyc(); reset = 1'b0;
    @(negedge clk);
    check("a_c0_fetch_req", fetch_req, 1'b0);
    check("a_c0_wrap_req", w_fetch_req, 1'b0);
    cyc(); @(negedge clk);
    check("a_c1_fetch_req", fetch_req, 1'b1);
    check("a_c1_im_addr", im_addr, 32'h0);
    check("a_c1_wrap_addr", w_im_addr, 32'hFFFF_FFFC);
    cyc(); @(negedge clk);
    check("a_c2_valid", instr_valid, 1'b0);
    check("a_c2_im_addr", im_addr, 32'h4);
    check("a_c2_wrap_addr", w_im_addr, 32'h0);
    cyc(); @(negedge clk);
    check("a_c3_valid", instr_valid, 1'b1);
    check("a_c3_instr", instr_out, 32'h0);
    check("a_c3_pc4", instr_pc4, 32'h4);
    cyc(); @(negedge clk);
    check("a_c4_instr", instr_out, 32'h4);
    check("a_c4_pc4", instr_pc4, 32'h8);

    // Back-pressure: ready low for four cycles from cycle 3.
    do_reset();
    cyc(); reset = 1'b0;
    @(negedge clk);
    run_cycles(2, 1'b0);
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("b_c3_instr", instr_out, 32'h0);
    check("b_c3_fetch_req", fetch_req, 1'b0);
    for (int k = 4; k <= 6; k++) begin
      cyc(); @(negedge clk);
      check($sformatf("b_c%0d_instr", k), instr_out, 32'h0);
      check($sformatf("b_c%0d_valid", k), instr_valid, 1'b1);
      check($sformatf("b_c%0d_fetch_req", k), fetch_req, 1'b0);
      check($sformatf("b_c%0d_outstanding", k), 32'(sb_q.size()), 32'd2);
    end
    cyc(); instr_ready = 1'b1;
    @(negedge clk);
    check("b_c7_instr", instr_out, 32'h0);
    cyc(); @(negedge clk);
    check("b_c8_instr", instr_out, 32'h4);
    cyc(); @(negedge clk);
    check("b_c9_instr", instr_out, 32'h8);

    // Table-driven redirects under random decode back-pressure.
    for (int i = 0; i < 8; i++) begin
      run_cycles(5, 1'b1);
      cyc();
      redir_exp   = vecs[i].exp;
      instr_ready = 1'($urandom_range(0, 1));
      drive_redir(vecs[i].kind, vecs[i].pc4, vecs[i].imm, vecs[i].tgt, vecs[i].jr);
      @(negedge clk);
      check($sformatf("redir%0d_fetch_req", i), fetch_req, 1'b0);
      cyc(); redirect = 1'b0;
      @(negedge clk);
      check($sformatf("redir%0d_im_addr", i), im_addr, vecs[i].exp);
      check($sformatf("redir%0d_valid", i), instr_valid, 1'b0);
    end
    run_cycles(6, 1'b0);

    // Reset with a response in flight and a simultaneous redirect,
    // then a redirect while IDLE.
    cyc(); reset = 1'b1; redir_exp = 32'h800;
    drive_redir(2'd2, 32'h0, 16'h0, 26'h0, 32'h0000_0800);
    @(negedge clk);
    check("d_rst_fetch_req", fetch_req, 1'b0);
    cyc(); reset = 1'b0; redir_exp = 32'h500;
    drive_redir(2'd1, 32'h0, 16'h0, 26'h0000140, 32'h0);
    @(negedge clk);
    check("d_c0_valid", instr_valid, 1'b0);
    check("d_c0_im_addr", im_addr, 32'h0);
    check("d_c0_fetch_req", fetch_req, 1'b0);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    check("d_c1_im_addr", im_addr, 32'h500);
    check("d_c1_fetch_req", fetch_req, 1'b1);
    cyc(); @(negedge clk);
    check("d_c2_valid", instr_valid, 1'b0);
    cyc(); @(negedge clk);
    check("d_c3_instr", instr_out, 32'h500);
    check("d_c3_pc4", instr_pc4, 32'h504);

    // Misaligned jump-register target.
    run_cycles(3, 1'b0);
    cyc();
    saved = model_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    redir_exp = saved;
`else
    redir_exp = 32'h1234;
`endif
    drive_redir(2'd2, 32'h0, 16'h0, 26'h0, 32'h0000_1236);
    @(negedge clk);
    check("e_fetch_req", fetch_req, 1'b0);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    check("e_valid", instr_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("e_misalign", misalign_err, 1'b1);
    check("e_pc_held", im_addr, saved);
    check("e_halt_req", fetch_req, 1'b0);
    cyc(); redir_exp = saved;
    drive_redir(2'd2, 32'h0, 16'h0, 26'h0, 32'h0000_2000);
    @(negedge clk);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    check("e_halt_ignore_addr", im_addr, saved);
    check("e_halt_ignore_req", fetch_req, 1'b0);
    check("e_sticky", misalign_err, 1'b1);
    do_reset();
    cyc(); reset = 1'b0;
    @(negedge clk);
`else
    check("e_forced_align", im_addr, 32'h1234);
    check("e_misalign", misalign_err, 1'b0);
`endif
    run_cycles(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
